// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers 4-digit frames from a multiplexed 7-segment scan
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] csn,
  input  logic [6:0] abcdefg,
  output logic [3:0] single_digit,
  output logic [3:0] ten_digit,
  output logic [3:0] hundred_digit,
  output logic [3:0] kilo_digit,
  output logic [3:0] digit_blank,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       link_active
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] SMAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, FILTER, HOLD} state_t;
  state_t state, state_nx;
  logic [3:0] csn_m, csn_s, sel, seen, seen_nx, blank_sh, blank_nx, dec_digit;
  logic [6:0] seg_m, seg_s;
  logic [10:0] cur, prev;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt;
  logic [3:0][3:0] sh, sh_nx;
  logic [1:0] pos;
  logic sel_ok, same, cap, good, dec_ok, dec_blank;
  assign cur = {csn_s, SEG_ACTIVE_LOW ? ~seg_s : seg_s};
  assign sel = ~csn_s;
  assign sel_ok = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign same = cur == prev;
  assign pos = !csn_s[0] ? 2'd0 : !csn_s[1] ? 2'd1 : !csn_s[2] ? 2'd2 : 2'd3;
  assign good = cap && dec_ok;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    cap = 1'b0;
    if (state == IDLE || !same) begin
      state_nx = sel_ok ? FILTER : IDLE;
      cnt_nx = sel_ok ? CW'(1) : '0;
    end else if (state == FILTER) begin
      cnt_nx = cnt + 1'b1;
      cap = cnt_nx == SMAX;
      state_nx = cap ? HOLD : FILTER;
    end
  end
  always_comb begin
    dec_ok = 1'b1;
    dec_blank = 1'b0;
    dec_digit = 4'd0;
    case (cur[6:0])
      7'h7E: dec_digit = 4'd0;
      7'h30: dec_digit = 4'd1;
      7'h6D: dec_digit = 4'd2;
      7'h79: dec_digit = 4'd3;
      7'h33: dec_digit = 4'd4;
      7'h5B: dec_digit = 4'd5;
      7'h5F: dec_digit = 4'd6;
      7'h70: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h7B: dec_digit = 4'd9;
      7'h00: dec_blank = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end
  always_comb begin
    sh_nx = sh;
    blank_nx = blank_sh;
    seen_nx = seen;
    if (good) begin
      sh_nx[pos] = dec_digit;
      blank_nx[pos] = dec_blank;
      seen_nx[pos] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_m <= '0;
      csn_s <= '0;
      seg_m <= '0;
      seg_s <= '0;
      prev <= '0;
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      seen <= '0;
      sh <= '0;
      blank_sh <= '0;
      single_digit <= '0;
      ten_digit <= '0;
      hundred_digit <= '0;
      kilo_digit <= '0;
      digit_blank <= '0;
      frame_valid <= 1'b0;
      seg_err <= 1'b0;
      link_active <= 1'b0;
    end else begin
      csn_m <= csn;
      csn_s <= csn_m;
      seg_m <= abcdefg;
      seg_s <= seg_m;
      prev <= cur;
      state <= state_nx;
      cnt <= cnt_nx;
      sh <= sh_nx;
      blank_sh <= blank_nx;
      seg_err <= cap && !dec_ok;
      frame_valid <= 1'b0;
      tcnt <= good ? '0 : (tcnt == TMAX ? tcnt : tcnt + 1'b1);
      if (seen == 4'hF) begin
        single_digit <= sh_nx[0];
        ten_digit <= sh_nx[1];
        hundred_digit <= sh_nx[2];
        kilo_digit <= sh_nx[3];
        digit_blank <= blank_nx;
        frame_valid <= 1'b1;
        seen <= '0;
        link_active <= 1'b1;
      end else if (!good && tcnt == TMAX) begin
        seen <= '0;
        link_active <= 1'b0;
      end else begin
        seen <= seen_nx;
      end
    end
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive side of the 4-digit multiplexed 7-segment scan interface (csn + abcdefg) that digital_tube drives.
- Samples the scanned select/segment lines, filters scan transitions and decodes each segment pattern back to a 4-bit digit.
- Publishes a coherent 4-digit frame once every digit position has been captured.
- Used as an in-system monitor and loopback checker for the display driver.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a capture (minimum 2).
- TIMEOUT, 1024: cycles without any capture before the link is declared inactive.
- SEG_ACTIVE_LOW, 0: 1 means segment inputs are inverted before decode.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- csn  in  4  digit select, active-low; csn[0]=single, csn[1]=ten, csn[2]=hundred, csn[3]=kilo
- abcdefg  in  7  segment lines, bit 6 = a ... bit 0 = g
- single_digit  out  4  decoded units digit
- ten_digit  out  4  decoded tens digit
- hundred_digit  out  4  decoded hundreds digit
- kilo_digit  out  4  decoded thousands digit
- digit_blank  out  4  per-position flag, pattern was all-off; bit order as csn
- frame_valid  out  1  one-cycle pulse; digit outputs were updated this cycle
- seg_err  out  1  one-cycle pulse; undecodable pattern captured
- link_active  out  1  level; frames are arriving

Behaviour:
- Reset (async, rst=1): all digit outputs 0, digit_blank 0, frame_valid 0, seg_err 0, link_active 0. Synchronizers, filter counter, seen mask, shadow registers and timeout counter are cleared. Reset asserted mid-frame discards all partial captures.
- Input path: csn and abcdefg pass through 2-flop synchronizers, then optional inversion (SEG_ACTIVE_LOW).
- Valid select: exactly one csn bit is low. All-high (blanking gap) or multiple low counts as no select.
- Filter FSM:
  - IDLE: no valid select. Filter counter held at 0.
  - FILTER: entered on a valid select. Counter increments each cycle the synchronized {csn, seg} equals the previous cycle's value. Any change restarts the count at 1 with the new value, or returns to IDLE if the new value is no select.
  - Capture: on the STABLE_CYCLES-th consecutive identical sample, the FSM moves to HOLD.
  - HOLD: no further capture until {csn, seg} changes. A change of seg under the same csn re-enters FILTER and may recapture; the latest capture wins.
- Decode, abcdefg hex to digit: 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
  - 00 means blank: shadow digit = 0 and blank bit set.
  - Any other pattern: seg_err pulses on the cycle after capture, the shadow digit and blank bit are unchanged, and the seen bit is not set.
- Frame assembly:
  - A valid capture writes the shadow digit and blank bit, and sets the seen bit for that position.
  - When the seen mask becomes 4'b1111, on the next clock edge: outputs load from the shadow registers, frame_valid pulses for 1 cycle, the seen mask clears and link_active sets to 1.
  - Outputs change only at frame_valid.
- Latency: from a settled input change to capture is 2 (synchronizer) + STABLE_CYCLES cycles. The frame output follows the 4th capture by 1 cycle.
- Timeout:
  - The counter resets on every valid capture and saturates at TIMEOUT.
  - On reaching TIMEOUT: link_active drops to 0 and the seen mask clears. Digit outputs hold their last values.
- Simultaneous events: a capture on the same cycle as a timeout causes the capture to take precedence and the counter to reset. A capture completing the mask on the same cycle the mask is read is counted in that frame.
- Counter widths: $clog2(STABLE_CYCLES+1) and $clog2(TIMEOUT+1). No wrap-around; both counters saturate.

Test Plan:
- Drive a scan with digits 2,4,5,0 at 10 cycles per digit and 2-cycle all-high gaps -> frame_valid pulses once per scan; single=2, ten=4, hundred=5, kilo=0; digit_blank=0; link_active=1.
- Apply a 2-cycle glitch (csn=1110, seg=7F) inside a gap -> no capture, no seen bit, outputs unchanged.
- Drive kilo position with seg=00 -> kilo_digit=0, digit_blank=4'b1000 at the next frame_valid.
- Drive ten position with seg=01 -> seg_err pulses once; no frame_valid until a valid ten capture (seg=30 gives ten=1).
- Drive csn=1100 (two selects low) with stable segments -> no capture. Then stop scanning for TIMEOUT cycles -> link_active=0, digits hold their last frame.
- Assert rst after 3 of 4 captures, then resume the scan -> no frame_valid until all 4 positions are recaptured after reset.
